// File: rtl/clock_pkg.sv
// Shared field widths, limits and the set-select encoding for the digital clock core.
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_SEC  = 2'b01,
        SEL_MIN  = 2'b10,
        SEL_HOUR = 2'b11
    } set_sel_t;

    // Anything at or beyond the field maximum folds back to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler dividing the system clock down to a one-cycle internal 1 Hz tick.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_term;

    always_comb begin
        at_term = (cnt_q == TERM);
        tick    = run && at_term && !clr;
        cnt_d   = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (run)
            cnt_d = at_term ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/time_counter.sv
// Hours/minutes/seconds timekeeping with manual field setting and day rollover flag.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr,
    input  logic [1:0]        set_sel,
    input  logic              inc,
    output logic [SEC_W-1:0]  sec_val,
    output logic [MIN_W-1:0]  min_val,
    output logic [HOUR_W-1:0] hour_val,
    output logic              tick_1hz,
    output logic              day_wrap
);

    logic              tick;
    set_sel_t          sel;
    logic              set_req;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic [SEC_W-1:0]  sec_nx;
    logic [MIN_W-1:0]  min_nx;
    logic [HOUR_W-1:0] hour_nx;

    // clr also blocks the prescaler tick inside tick_gen.
    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        sel     = set_sel_t'(set_sel);
        set_req = inc && (sel != SEL_NONE);
        sec_nx  = wrap_inc(sec_q, SEC_MAX);
        min_nx  = wrap_inc(min_q, MIN_MAX);
        hour_nx = HOUR_W'(wrap_inc({1'b0, hour_q}, {1'b0, HOUR_MAX}));

        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;

        // Priority: clr, then a valid set increment, then the 1 Hz tick.
        if (clr) begin
            sec_d = '0;
        end else if (set_req) begin
            unique case (sel)
                SEL_SEC:  sec_d  = sec_nx;
                SEL_MIN:  min_d  = min_nx;
                SEL_HOUR: hour_d = hour_nx;
                default:  ;
            endcase
        end else if (tick) begin
            tick_d = 1'b1;
            sec_d  = sec_nx;
            if (sec_q >= SEC_MAX) begin
                min_d = min_nx;
                if (min_q >= MIN_MAX) begin
                    hour_d = hour_nx;
                    wrap_d = (hour_q >= HOUR_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign sec_val  = sec_q;
    assign min_val  = min_q;
    assign hour_val = hour_q;
    assign tick_1hz = tick_q;
    assign day_wrap = wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter with a small prescaler (CLK_HZ=4).
module tb_time_counter;

    localparam int CLK_HZ = 4;

    logic       clk;
    logic       rst;
    logic       run;
    logic       clr;
    logic [1:0] set_sel;
    logic       inc;
    logic [5:0] sec_val;
    logic [5:0] min_val;
    logic [4:0] hour_val;
    logic       tick_1hz;
    logic       day_wrap;

    time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr      (clr),
        .set_sel  (set_sel),
        .inc      (inc),
        .sec_val  (sec_val),
        .min_val  (min_val),
        .hour_val (hour_val),
        .tick_1hz (tick_1hz),
        .day_wrap (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int m;
        int h;
        int t;
        int w;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_pre, m_sec, m_min, m_hour;

    task automatic chk(input string tag, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_sec  = 0;
        m_min  = 0;
        m_hour = 0;
    endtask

    // Reference behaviour for one clock edge given the currently driven inputs.
    task automatic model(output exp_t e);
        bit tk;
        tk  = run && (m_pre == CLK_HZ - 1) && !clr;
        e.t = 0;
        e.w = 0;
        if (clr)      m_pre = 0;
        else if (run) m_pre = (m_pre == CLK_HZ - 1) ? 0 : m_pre + 1;
        if (clr) begin
            m_sec = 0;
        end else if (inc && set_sel != 2'b00) begin
            case (set_sel)
                2'b01:   m_sec  = (m_sec + 1) % 60;
                2'b10:   m_min  = (m_min + 1) % 60;
                default: m_hour = (m_hour + 1) % 24;
            endcase
        end else if (tk) begin
            e.t = 1;
            if (m_sec == 59) begin
                m_sec = 0;
                if (m_min == 59) begin
                    m_min = 0;
                    if (m_hour == 23) begin
                        m_hour = 0;
                        e.w = 1;
                    end else m_hour++;
                end else m_min++;
            end else m_sec++;
        end
        e.s = m_sec;
        e.m = m_min;
        e.h = m_hour;
    endtask

    task automatic step();
        exp_t e;
        model(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sec", int'(sec_val), e.s);
        chk("min", int'(min_val), e.m);
        chk("hour", int'(hour_val), e.h);
        chk("tick", int'(tick_1hz), e.t);
        chk("wrap", int'(day_wrap), e.w);
        inc = 1'b0;
        clr = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] s);
        set_sel = s;
        inc     = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        rst     = 1'b1;
        run     = 1'b1;
        clr     = 1'b0;
        set_sel = 2'b00;
        inc     = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_sec", int'(sec_val), 0);
        chk("rst_min", int'(min_val), 0);
        chk("rst_hour", int'(hour_val), 0);
        chk("rst_tick", int'(tick_1hz), 0);
        chk("rst_wrap", int'(day_wrap), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        // Free run: 40 cycles -> 10 seconds
        for (int i = 0; i < 40; i++) step();
        chk("t1_sec10", int'(sec_val), 10);
        chk("t1_min0", int'(min_val), 0);

        // Preset 23:59:58 then roll over the day
        run = 1'b0;
        for (int i = 0; i < 30 && m_hour != 23; i++) pulse(2'b11);
        for (int i = 0; i < 70 && m_min != 59; i++) pulse(2'b10);
        for (int i = 0; i < 70 && m_sec != 58; i++) pulse(2'b01);
        chk("t2_preset_sec", int'(sec_val), 58);
        run = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t2_sec59", int'(sec_val), 59);
        chk("t2_hour23", int'(hour_val), 23);
        for (int i = 0; i < 4; i++) step();
        chk("t2_wrap_hour", int'(hour_val), 0);
        chk("t2_wrap_min", int'(min_val), 0);
        chk("t2_wrap_sec", int'(sec_val), 0);
        chk("t2_wrap_flag", int'(day_wrap), 1);
        chk("t2_wrap_tick", int'(tick_1hz), 1);
        step();
        chk("t2_wrap_once", int'(day_wrap), 0);

        // Minute set has no carry; set_sel=00 ignores inc
        run = 1'b0;
        for (int i = 0; i < 30 && m_hour != 5; i++) pulse(2'b11);
        for (int i = 0; i < 70 && m_min != 59; i++) pulse(2'b10);
        pulse(2'b10);
        chk("t3_min0", int'(min_val), 0);
        chk("t3_hour5", int'(hour_val), 5);
        pulse(2'b00);
        chk("t3_none_min", int'(min_val), 0);
        chk("t3_none_hour", int'(hour_val), 5);
        chk("t3_none_sec", int'(sec_val), 0);

        // Inc collides with the internal tick at sec=59
        for (int i = 0; i < 70 && m_sec != 59; i++) pulse(2'b01);
        run = 1'b1;
        for (int i = 0; i < 8 && m_pre != CLK_HZ - 1; i++) step();
        pulse(2'b01);
        chk("t4_sec0", int'(sec_val), 0);
        chk("t4_min0", int'(min_val), 0);
        chk("t4_notick", int'(tick_1hz), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_wait", int'(tick_1hz), 0);
        end
        step();
        chk("t4_tick", int'(tick_1hz), 1);

        // Freeze mid-second
        step();
        step();
        s0  = m_sec;
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_frozen_tick", int'(tick_1hz), 0);
        end
        chk("t5_frozen_sec", int'(sec_val), s0);
        run = 1'b1;
        step();
        chk("t5_resume_wait", int'(tick_1hz), 0);
        step();
        chk("t5_resume_tick", int'(tick_1hz), 1);

        // clr at 12:34:56 with prescaler at 2
        for (int i = 0; i < 8 && m_pre != 2; i++) step();
        run = 1'b0;
        for (int i = 0; i < 30 && m_hour != 12; i++) pulse(2'b11);
        for (int i = 0; i < 70 && m_min != 34; i++) pulse(2'b10);
        for (int i = 0; i < 70 && m_sec != 56; i++) pulse(2'b01);
        chk("t6_preset_sec", int'(sec_val), 56);
        run = 1'b1;
        clr = 1'b1;
        step();
        chk("t6_clr_sec", int'(sec_val), 0);
        chk("t6_clr_min", int'(min_val), 34);
        chk("t6_clr_hour", int'(hour_val), 12);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_pre_zero", int'(tick_1hz), 0);
        end
        step();
        chk("t6_tick", int'(tick_1hz), 1);
        chk("t6_sec1", int'(sec_val), 1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("t7_async_sec", int'(sec_val), 0);
        chk("t7_async_min", int'(min_val), 0);
        chk("t7_async_hour", int'(hour_val), 0);
        chk("t7_async_tick", int'(tick_1hz), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t7_resume_tick", int'(tick_1hz), 1);
        chk("t7_resume_sec", int'(sec_val), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
Timekeeping core of the digital clock. It divides the system clock to a 1 Hz tick and maintains hours, minutes and seconds in binary. It supports manual setting of each field. It feeds the downstream per-field 7-segment converters: sec_val to the seconds converter, and min_val/hour_val to their equivalents.

Parameters:
CLK_HZ, 50_000_000, system clock cycles per second; the prescaler terminal count is CLK_HZ-1 (set small, e.g. 4, in simulation)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  1 = time advances; 0 = prescaler and time frozen
clr  input  1  synchronous single-cycle pulse: zero seconds and prescaler
set_sel  input  2  field select for inc: 00 none, 01 sec, 10 min, 11 hour
inc  input  1  synchronous single-cycle pulse: increment selected field (already debounced upstream)
sec_val  output  6  seconds 0..59, binary
min_val  output  6  minutes 0..59, binary
hour_val  output  5  hours 0..23, binary
tick_1hz  output  1  one-cycle pulse per second tick
day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset (rst=0, async): prescaler=0, sec_val=0, min_val=0, hour_val=0, tick_1hz=0, day_wrap=0.
- Prescaler: counts while run=1. At count==CLK_HZ-1 it wraps to 0 and raises an internal tick for that cycle. With run=0 it holds its value and no tick is produced. Width is $clog2(CLK_HZ).
- tick_1hz is registered: it is high in the cycle after the prescaler reaches terminal count, the same cycle the new time appears on the outputs.
- Tick carry chain, applied in one clock:
  - sec 59->0 carries to min.
  - min 59->0 carries to hour.
  - hour 23->0 with sec=59 and min=59 asserts day_wrap, registered and aligned with the outputs.
- All outputs are registered. Latency from tick to output update is 1 cycle.
- inc (set_sel!=00): the selected field increments modulo its range (60/60/24) with no carry into higher fields, and no day_wrap. inc with set_sel=00 is ignored. inc is honoured regardless of run.
- clr: sec_val=0 and prescaler=0 next cycle. Minutes and hours are unchanged, and no tick is produced that cycle.
- Priority within one cycle, highest first: clr, then inc (set_sel!=00), then tick.
  - A tick coinciding with clr or a valid inc is dropped entirely: no time advance and tick_1hz=0. The prescaler still wraps (or is zeroed by clr).
- Outputs never leave their legal ranges. An out-of-range value is unreachable, but the next-value logic maps any value >= max to 0 defensively.
- Reset mid-count: all state clears immediately, and counting resumes from 0 after rst deasserts if run=1.

Decomposition:
- Package clock_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - field widths SEC_W=6, MIN_W=6, HOUR_W=5
  - enum set_sel_t {SEL_NONE, SEL_SEC, SEL_MIN, SEL_HOUR}
- One sub-module, tick_gen (parameter CLK_HZ; ports clk, rst, run, clr, tick), holds the prescaler. time_counter instantiates it and contains the field registers and carry logic.

Test Plan:
- CLK_HZ=4, rst low then high, run=1 for 40 cycles -> tick_1hz pulses every 4th cycle; sec_val reaches 10; min_val=0, hour_val=0.
- Preset via inc to 23:59:58, run for 8 cycles -> after tick 1, 23:59:59. After tick 2, 00:00:00 with day_wrap=1 for exactly one cycle, coincident with tick_1hz.
- set_sel=10 with min_val=59 and hour_val=5, pulse inc -> min_val=0 and hour_val stays 5 (no carry). set_sel=00 plus inc -> no change.
- sec_val=59, inc with set_sel=01 in the same cycle as the internal tick -> sec_val=0 and min_val unchanged. tick_1hz stays 0, and the next tick occurs 4 cycles later.
- run=0 for 20 cycles mid-second -> outputs and prescaler frozen, no tick_1hz. run=1 -> the remaining prescaler count completes before the next tick.
- At 12:34:56 with the prescaler at 2, pulse clr -> 12:34:00 next cycle with the prescaler at 0. Asserting rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
